// File: rtl/dm_pkg.sv
// Shared definitions for the data memory: access-size encodings and the
// size/lane to byte-enable mapping.
package dm_pkg;

    typedef enum logic [1:0] {
        DM_BYTE    = 2'b00,
        DM_HALF    = 2'b01,
        DM_WORD    = 2'b10,
        DM_ILLEGAL = 2'b11
    } dm_size_e;

    // Byte enables for an access of the given size starting at the given lane.
    // Misaligned combinations are rejected by the fault check, not here.
    function automatic logic [3:0] lane_mask(input dm_size_e size, input logic [1:0] lane);
        logic [3:0] mask;
        mask = '0;
        case (size)
            DM_BYTE: mask = 4'b0001 << lane;
            DM_HALF: mask = lane[1] ? 4'b1100 : 4'b0011;
            DM_WORD: mask = 4'b1111;
            default: mask = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Lane steering for the data memory: replicates store data across lanes with
// byte enables, and extracts/extends the addressed lane(s) on loads.
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        load_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] word_rdata,
    output logic [31:0] wdata_lanes,
    output logic [3:0]  byte_en,
    output logic [31:0] load_data
);

    dm_size_e sz;
    assign sz = dm_size_e'(size);

    always_comb begin
        byte_en = lane_mask(sz, lane);
        case (sz)
            DM_BYTE: wdata_lanes = {4{wdata[7:0]}};
            DM_HALF: wdata_lanes = {2{wdata[15:0]}};
            default: wdata_lanes = wdata;
        endcase
    end

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        case (lane)
            2'd0:    sel_byte = word_rdata[7:0];
            2'd1:    sel_byte = word_rdata[15:8];
            2'd2:    sel_byte = word_rdata[23:16];
            default: sel_byte = word_rdata[31:24];
        endcase
        sel_half = lane[1] ? word_rdata[31:16] : word_rdata[15:0];

        case (sz)
            DM_BYTE: load_data = {{24{sel_byte[7] & ~load_unsigned}}, sel_byte};
            DM_HALF: load_data = {{16{sel_half[15] & ~load_unsigned}}, sel_half};
            DM_WORD: load_data = word_rdata;
            default: load_data = '0;
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// Word-organised data memory with byte/half/word access, combinational loads,
// and first-fault capture for debug.
module data_memory
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [1:0]  mem_size,
    input  logic        load_unsigned,
    input  logic [31:0] pc,
    output logic [31:0] rdata,
    output logic        fault,
    output logic        fault_sticky,
    output logic [31:0] fault_addr,
    output logic [31:0] fault_pc
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]      offset;
    logic [31:0]      word_idx;
    logic [1:0]       lane;
    logic [IDX_W-1:0] idx;
    logic             misaligned;
    logic             out_of_range;
    dm_size_e         sz;

    always_comb begin
        sz           = dm_size_e'(mem_size);
        offset       = addr - BASE_ADDR;
        word_idx     = {2'b00, offset[31:2]};
        lane         = offset[1:0];
        idx          = word_idx[IDX_W-1:0];
        misaligned   = (sz == DM_ILLEGAL) ||
                       (sz == DM_HALF && lane[0]) ||
                       (sz == DM_WORD && lane != 2'd0);
        out_of_range = (word_idx >= DEPTH_WORDS) || (addr < BASE_ADDR);
        fault        = (mem_read || mem_write) && (misaligned || out_of_range);
    end

    logic [31:0] word_rdata;
    logic [31:0] wdata_lanes;
    logic [3:0]  byte_en;
    logic [31:0] load_data;

    // idx is truncated; an out-of-range access reads an alias but is masked by fault
    assign word_rdata = mem[idx];

    dm_lane_align u_align (
        .size          (mem_size),
        .lane          (lane),
        .load_unsigned (load_unsigned),
        .wdata         (wdata),
        .word_rdata    (word_rdata),
        .wdata_lanes   (wdata_lanes),
        .byte_en       (byte_en),
        .load_data     (load_data)
    );

    assign rdata = (mem_read && !fault) ? load_data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned w = 0; w < DEPTH_WORDS; w++) begin
                mem[w] <= '0;
            end
        end else if (mem_write && !fault) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[idx][b*8 +: 8] <= wdata_lanes[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_sticky <= 1'b0;
            fault_addr   <= '0;
            fault_pc     <= '0;
        end else if (fault && !fault_sticky) begin
            fault_sticky <= 1'b1;
            fault_addr   <= addr;
            fault_pc     <= pc;
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Directed, table-driven bench for data_memory with hand-written sequences
// for fault capture and mid-cycle reset.
module tb_data_memory;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_write;
    logic        mem_read;
    logic [1:0]  mem_size;
    logic        load_unsigned;
    logic [31:0] pc;
    logic [31:0] rdata;
    logic        fault;
    logic        fault_sticky;
    logic [31:0] fault_addr;
    logic [31:0] fault_pc;

    data_memory #(
        .DEPTH_WORDS (1024),
        .BASE_ADDR   (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .addr          (addr),
        .wdata         (wdata),
        .mem_write     (mem_write),
        .mem_read      (mem_read),
        .mem_size      (mem_size),
        .load_unsigned (load_unsigned),
        .pc            (pc),
        .rdata         (rdata),
        .fault         (fault),
        .fault_sticky  (fault_sticky),
        .fault_addr    (fault_addr),
        .fault_pc      (fault_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        re;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] p;
        logic [31:0] exp_rdata;
        logic        exp_fault;
        logic        exp_sticky;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic re, input logic [1:0] size, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] p,
                       input logic [31:0] er, input logic ef, input logic es);
        vec_t v;
        v.we = we; v.re = re; v.size = size; v.uns = uns; v.a = a; v.wd = wd; v.p = p;
        v.exp_rdata = er; v.exp_fault = ef; v.exp_sticky = es;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic we, input logic re, input logic [1:0] size, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] p);
        mem_write = we; mem_read = re; mem_size = size; load_unsigned = uns;
        addr = a; wdata = wd; pc = p;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0);
    endtask

    // Watchdog: the bench has no open-ended waits, but never let it hang.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

    initial begin
        //   we    re    size   uns   addr          wdata         pc            rdata         flt   sticky
        add(1'b0, 1'b1, 2'b10, 1'b0, 32'h10,       32'h0,        32'h100,      32'h0,        1'b0, 1'b0);
        add(1'b1, 1'b0, 2'b10, 1'b0, 32'h20,       32'h11223344, 32'h104,      32'h0,        1'b0, 1'b0);
        add(1'b1, 1'b0, 2'b00, 1'b0, 32'h21,       32'h000000AA, 32'h108,      32'h0,        1'b0, 1'b0);
        add(1'b0, 1'b1, 2'b10, 1'b0, 32'h20,       32'h0,        32'h10C,      32'h1122AA44, 1'b0, 1'b0);
        add(1'b0, 1'b1, 2'b00, 1'b0, 32'h21,       32'h0,        32'h110,      32'hFFFFFFAA, 1'b0, 1'b0);
        add(1'b0, 1'b1, 2'b00, 1'b1, 32'h21,       32'h0,        32'h114,      32'h000000AA, 1'b0, 1'b0);
        add(1'b1, 1'b0, 2'b01, 1'b0, 32'h22,       32'h00008001, 32'h118,      32'h0,        1'b0, 1'b0);
        add(1'b0, 1'b1, 2'b01, 1'b0, 32'h22,       32'h0,        32'h11C,      32'hFFFF8001, 1'b0, 1'b0);
        add(1'b0, 1'b1, 2'b01, 1'b1, 32'h22,       32'h0,        32'h120,      32'h00008001, 1'b0, 1'b0);
        add(1'b0, 1'b1, 2'b10, 1'b0, 32'h20,       32'h0,        32'h124,      32'h8001AA44, 1'b0, 1'b0);
        add(1'b0, 1'b1, 2'b00, 1'b1, 32'h23,       32'h0,        32'h128,      32'h00000080, 1'b0, 1'b0);
        add(1'b0, 1'b1, 2'b00, 1'b0, 32'h23,       32'h0,        32'h12C,      32'hFFFFFF80, 1'b0, 1'b0);
        add(1'b0, 1'b1, 2'b01, 1'b0, 32'h20,       32'h0,        32'h130,      32'hFFFFAA44, 1'b0, 1'b0);
        add(1'b0, 1'b0, 2'b10, 1'b0, 32'h20,       32'h0,        32'h134,      32'h0,        1'b0, 1'b0);
        add(1'b1, 1'b0, 2'b10, 1'b0, 32'h24,       32'hCAFEF00D, 32'h138,      32'h0,        1'b0, 1'b0);
        add(1'b0, 1'b0, 2'b11, 1'b0, 32'h26,       32'h0,        32'h13C,      32'h0,        1'b0, 1'b0);
        // First fault: misaligned word store
        add(1'b1, 1'b0, 2'b10, 1'b0, 32'h26,       32'hDEADBEEF, 32'h3000,     32'h0,        1'b1, 1'b0);
        add(1'b0, 1'b1, 2'b10, 1'b0, 32'h24,       32'h0,        32'h140,      32'hCAFEF00D, 1'b0, 1'b1);
        // Out-of-range store must not alias onto word 0
        add(1'b1, 1'b1, 2'b10, 1'b0, 32'h1000,     32'h77777777, 32'h3004,     32'h0,        1'b1, 1'b1);
        add(1'b0, 1'b1, 2'b10, 1'b0, 32'h0,        32'h0,        32'h144,      32'h0,        1'b0, 1'b1);
        add(1'b0, 1'b1, 2'b10, 1'b0, 32'hFFC,      32'h0,        32'h148,      32'h0,        1'b0, 1'b1);
        add(1'b0, 1'b1, 2'b01, 1'b0, 32'h23,       32'h0,        32'h14C,      32'h0,        1'b1, 1'b1);
        add(1'b0, 1'b1, 2'b11, 1'b0, 32'h20,       32'h0,        32'h150,      32'h0,        1'b1, 1'b1);
        add(1'b0, 1'b1, 2'b00, 1'b1, 32'hFFFFFFFF, 32'h0,        32'h154,      32'h0,        1'b1, 1'b1);
        // Simultaneous read and write shows old data, new data next cycle
        add(1'b1, 1'b0, 2'b10, 1'b0, 32'h30,       32'h5,        32'h158,      32'h0,        1'b0, 1'b1);
        add(1'b1, 1'b1, 2'b10, 1'b0, 32'h30,       32'h9,        32'h15C,      32'h5,        1'b0, 1'b1);
        add(1'b0, 1'b1, 2'b10, 1'b0, 32'h30,       32'h0,        32'h160,      32'h9,        1'b0, 1'b1);

        rst_n = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #2;
        check("reset_rdata", rdata, 32'h0);
        check("reset_fault", {31'b0, fault}, 32'h0);
        check("reset_sticky", {31'b0, fault_sticky}, 32'h0);
        check("reset_fault_addr", fault_addr, 32'h0);
        check("reset_fault_pc", fault_pc, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i].we, vecs[i].re, vecs[i].size, vecs[i].uns, vecs[i].a, vecs[i].wd, vecs[i].p);
            #3;
            check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_fault", i), {31'b0, fault}, {31'b0, vecs[i].exp_fault});
            check($sformatf("vec%0d_sticky", i), {31'b0, fault_sticky}, {31'b0, vecs[i].exp_sticky});
        end

        @(posedge clk);
        #1;
        idle();
        #3;
        check("first_fault_addr", fault_addr, 32'h26);
        check("first_fault_pc", fault_pc, 32'h3000);

        // Committed store at 0x40, then a store interrupted by mid-cycle reset
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'hA5A5A5A5, 32'h200);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h0, 32'h204);
        #3;
        check("pre_reset_0x40", rdata, 32'hA5A5A5A5);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h12345678, 32'h208);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_sticky", {31'b0, fault_sticky}, 32'h0);
        check("async_reset_fault_addr", fault_addr, 32'h0);
        check("async_reset_fault_pc", fault_pc, 32'h0);
        @(posedge clk);
        #1;
        idle();
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h0, 32'h20C);
        #3;
        check("post_reset_0x40", rdata, 32'h0);
        check("post_reset_fault", {31'b0, fault}, 32'h0);
        check("post_reset_sticky", {31'b0, fault_sticky}, 32'h0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h0, 32'h210);
        #3;
        check("post_reset_0x20", rdata, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
